uplink_tx_framer: RTL and testbench



---
 rtl/uplink_tx_pkg.sv | 14 +
 rtl/uplink_tx_framer_byte_fifo.sv | 61 ++++++
 rtl/uplink_tx_framer.sv | 132 +++++++++++++
 tb/tb_uplink_tx_framer.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uplink_tx_pkg.sv
// Shared types and widths for the uplink transmit framer and its byte FIFO.
// Pure declarations: no logic, no latency, no flow control.
package uplink_tx_pkg;

   localparam int BYTE_W = 8;
   localparam int LEN_W  = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/uplink_tx_framer_byte_fifo.sv
// Show-ahead byte FIFO; a write is readable the next cycle, count updates one cycle after a push/pop.
// Writes are refused only when full with no pop in the same cycle; flush empties it but keeps a same-cycle write.
module byte_fifo
   import uplink_tx_pkg::*;
#(
   parameter int DEPTH  = 2048,
   parameter int ADDR_W = 11
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [BYTE_W-1:0] wr_data,
   output logic              full,
   input  logic              rd_en,
   output logic [BYTE_W-1:0] rd_data,
   output logic              empty,
   output logic [ADDR_W:0]   count,
   input  logic              flush
);

   localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

   logic [BYTE_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic              wr_ok;
   logic              rd_ok;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign rd_ok   = rd_en & ~empty;
   // A pop in the same cycle frees the slot, so a full FIFO still takes the write.
   assign wr_ok   = wr_en & (~full | rd_ok);
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
         if (flush) begin
            rd_ptr <= wr_ptr;
            count  <= {{ADDR_W{1'b0}}, wr_ok};
         end else begin
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, rd_ok})
               2'b10:   count <= count + 1'b1;
               2'b01:   count <= count - 1'b1;
               default: count <= count;
            endcase
         end
      end
   end

endmodule

// File: rtl/uplink_tx_framer.sv
// Buffers host bytes and, on a tx_en rising edge, streams a length-delimited frame with sop/eop markers.
// Byte visible one cycle after its write; holds data while tx_ready=0, aborts after TIMEOUT empty cycles.
module uplink_tx_framer
   import uplink_tx_pkg::*;
#(
   parameter int DEPTH   = 2048,
   parameter int ADDR_W  = 11,
   parameter int TIMEOUT = 65535
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [BYTE_W-1:0] wrfifo_data,
   input  logic              wrfifo_pulse,
   input  logic              tx_en,
   input  logic [LEN_W-1:0]  tx_datalength,
   output logic [BYTE_W-1:0] tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic              tx_sop,
   output logic              tx_eop,
   output logic              busy,
   output logic [ADDR_W:0]   fifo_count,
   output logic              overflow,
   output logic              frame_done,
   output logic              frame_error
);

   localparam logic [LEN_W:0]   DEPTH_L   = (LEN_W+1)'(DEPTH);
   localparam logic [LEN_W-1:0] STALL_LIM = LEN_W'(TIMEOUT - 1);

   state_t            state, state_nxt;
   logic [LEN_W-1:0]  remaining, remaining_nxt;
   logic [LEN_W-1:0]  stall_cnt, stall_nxt;
   logic              first, first_nxt;
   logic              tx_en_q;
   logic              tx_rise;
   logic              err_nxt;
   logic              flush;
   logic              handshake;
   logic              fifo_full;
   logic              fifo_empty;
   logic [BYTE_W-1:0] rd_data;

   byte_fifo #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wrfifo_pulse),
      .wr_data (wrfifo_data),
      .full    (fifo_full),
      .rd_en   (handshake),
      .rd_data (rd_data),
      .empty   (fifo_empty),
      .count   (fifo_count),
      .flush   (flush)
   );

   assign tx_rise    = tx_en & ~tx_en_q;
   assign tx_valid   = (state == SEND) & ~fifo_empty;
   assign handshake  = tx_valid & tx_ready;
   // Memory is not reset, so mask the show-ahead byte whenever it is not offered.
   assign tx_data    = tx_valid ? rd_data : '0;
   assign tx_sop     = first & tx_valid;
   assign tx_eop     = (remaining == LEN_W'(1)) & tx_valid;
   assign busy       = (state != IDLE);
   assign frame_done = (state == DONE);

   always_comb begin
      state_nxt     = state;
      remaining_nxt = remaining;
      first_nxt     = first;
      stall_nxt     = stall_cnt;
      err_nxt       = 1'b0;
      flush         = 1'b0;
      case (state)
         IDLE: begin
            if (tx_rise && tx_datalength != '0) begin
               if ({1'b0, tx_datalength} > DEPTH_L) begin
                  err_nxt = 1'b1;
                  flush   = 1'b1;
               end else begin
                  remaining_nxt = tx_datalength;
                  first_nxt     = 1'b1;
                  stall_nxt     = '0;
                  state_nxt     = SEND;
               end
            end
         end
         SEND: begin
            if (handshake) begin
               first_nxt = 1'b0;
               stall_nxt = '0;
               if (remaining == LEN_W'(1)) state_nxt = DONE;
               else                        remaining_nxt = remaining - 1'b1;
            end else if (fifo_empty) begin
               if (TIMEOUT != 0 && stall_cnt == STALL_LIM) begin
                  err_nxt   = 1'b1;
                  state_nxt = IDLE;
               end else if (stall_cnt != '1) begin
                  stall_nxt = stall_cnt + 1'b1;
               end
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         remaining   <= '0;
         stall_cnt   <= '0;
         first       <= 1'b0;
         tx_en_q     <= 1'b0;
         overflow    <= 1'b0;
         frame_error <= 1'b0;
      end else begin
         state       <= state_nxt;
         remaining   <= remaining_nxt;
         stall_cnt   <= stall_nxt;
         first       <= first_nxt;
         tx_en_q     <= tx_en;
         frame_error <= err_nxt;
         if (wrfifo_pulse && fifo_full && !handshake) overflow <= 1'b1;
         else if (state == DONE)                      overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uplink_tx_framer.sv
// Directed bench for uplink_tx_framer with a 16-byte FIFO and a 100-cycle stall timeout.
// Inputs change on the falling edge; outputs are sampled on or just after the falling edge.
module tb_uplink_tx_framer;

   logic       clk;
   logic       rst;
   logic [7:0] wrfifo_data;
   logic       wrfifo_pulse;
   logic       tx_en;
   logic [15:0] tx_datalength;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       tx_sop;
   logic       tx_eop;
   logic       busy;
   logic [4:0] fifo_count;
   logic       overflow;
   logic       frame_done;
   logic       frame_error;

   int checks = 0;
   int errors = 0;

   uplink_tx_framer #(.DEPTH(16), .ADDR_W(4), .TIMEOUT(100)) dut (
      .clk           (clk),
      .rst           (rst),
      .wrfifo_data   (wrfifo_data),
      .wrfifo_pulse  (wrfifo_pulse),
      .tx_en         (tx_en),
      .tx_datalength (tx_datalength),
      .tx_data       (tx_data),
      .tx_valid      (tx_valid),
      .tx_ready      (tx_ready),
      .tx_sop        (tx_sop),
      .tx_eop        (tx_eop),
      .busy          (busy),
      .fifo_count    (fifo_count),
      .overflow      (overflow),
      .frame_done    (frame_done),
      .frame_error   (frame_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic push(input logic [7:0] d);
      wrfifo_data  = d;
      wrfifo_pulse = 1'b1;
      @(negedge clk);
      wrfifo_pulse = 1'b0;
   endtask

   task automatic start_frame(input logic [15:0] len);
      tx_datalength = len;
      tx_en = 1'b1;
      @(negedge clk);
      tx_en = 1'b0;
   endtask

   task automatic test_reset();
      checks++;
      if ({tx_valid, tx_sop, tx_eop, busy, overflow, frame_done, frame_error} !== 7'b0) begin
         errors++;
         $display("FAIL reset_flags got %b want 0000000", {tx_valid, tx_sop, tx_eop, busy, overflow, frame_done, frame_error});
      end
      checks++;
      if (fifo_count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d want 0", fifo_count); end
      checks++;
      if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", tx_data); end
   endtask

   task automatic test_basic();
      logic [7:0] exp [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      for (int i = 0; i < 4; i++) push(exp[i]);
      checks++;
      if (fifo_count !== 5'd4) begin errors++; $display("FAIL basic_count got %0d want 4", fifo_count); end
      tx_ready = 1'b1;
      start_frame(16'd4);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({tx_valid, tx_sop, tx_eop, tx_data} !== {1'b1, (i == 0), (i == 3), exp[i]}) begin
            errors++;
            $display("FAIL basic_byte%0d got v/s/e/d=%b%b%b/%h want 1%b%b/%h", i, tx_valid, tx_sop, tx_eop, tx_data, (i == 0), (i == 3), exp[i]);
         end
         @(negedge clk);
      end
      checks++;
      if ({frame_done, busy, fifo_count} !== {1'b1, 1'b1, 5'd0}) begin
         errors++; $display("FAIL basic_done got done=%b busy=%b cnt=%0d want 1 1 0", frame_done, busy, fifo_count);
      end
      @(negedge clk);
      checks++;
      if ({frame_done, busy} !== 2'b00) begin errors++; $display("FAIL basic_idle got done=%b busy=%b want 0 0", frame_done, busy); end
   endtask

   task automatic test_ready_toggle();
      logic [7:0] exp [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      logic [9:0] prev = '0;
      logic held = 1'b0;
      logic done = 1'b0;
      int n = 0;
      for (int i = 0; i < 4; i++) push(exp[i]);
      tx_ready = 1'b0;
      start_frame(16'd4);
      for (int c = 0; c < 40; c++) begin
         tx_ready = (c % 3 == 0);
         #1;
         if (tx_valid && held) begin
            checks++;
            if ({tx_sop, tx_eop, tx_data} !== prev) begin
               errors++; $display("FAIL toggle_hold c%0d got %h want %h", c, {tx_sop, tx_eop, tx_data}, prev);
            end
         end
         if (tx_valid && tx_ready) begin
            checks++;
            if (n >= 4) begin
               errors++; $display("FAIL toggle_extra got byte %h want none", tx_data);
            end else if ({tx_sop, tx_eop, tx_data} !== {(n == 0), (n == 3), exp[n]}) begin
               errors++; $display("FAIL toggle_byte%0d got %b%b/%h want %b%b/%h", n, tx_sop, tx_eop, tx_data, (n == 0), (n == 3), exp[n]);
            end
            n++;
         end
         held = tx_valid & ~tx_ready;
         prev = {tx_sop, tx_eop, tx_data};
         if (frame_done) begin done = 1'b1; break; end
         @(negedge clk);
      end
      @(negedge clk);
      checks++;
      if (!(done && n == 4)) begin errors++; $display("FAIL toggle_total got n=%0d done=%b want 4 1", n, done); end
   endtask

   task automatic test_gap();
      logic [7:0] exp [5] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
      int hs_c [5] = '{-1, -1, -1, -1, -1};
      int n = 0;
      int gapv = 0;
      logic done = 1'b0;
      push(exp[0]);
      push(exp[1]);
      tx_ready = 1'b1;
      start_frame(16'd5);
      for (int c = 0; c < 60; c++) begin
         if (c >= 20 && c <= 22) begin
            wrfifo_pulse = 1'b1;
            wrfifo_data  = exp[c-18];
         end else begin
            wrfifo_pulse = 1'b0;
         end
         #1;
         if (c >= 2 && c <= 20 && tx_valid) gapv++;
         if (tx_valid && tx_ready) begin
            checks++;
            if (n >= 5) begin
               errors++; $display("FAIL gap_extra got byte %h want none", tx_data);
            end else begin
               hs_c[n] = c;
               if ({tx_sop, tx_eop, tx_data} !== {(n == 0), (n == 4), exp[n]}) begin
                  errors++; $display("FAIL gap_byte%0d got %b%b/%h want %b%b/%h", n, tx_sop, tx_eop, tx_data, (n == 0), (n == 4), exp[n]);
               end
            end
            n++;
         end
         if (frame_done) begin done = 1'b1; break; end
         @(negedge clk);
      end
      wrfifo_pulse = 1'b0;
      @(negedge clk);
      checks++;
      if (gapv != 0) begin errors++; $display("FAIL gap_valid got %0d valid cycles want 0", gapv); end
      checks++;
      if (!(done && n == 5)) begin errors++; $display("FAIL gap_total got n=%0d done=%b want 5 1", n, done); end
      checks++;
      if (hs_c[0] != 0 || hs_c[2] != 21) begin
         errors++; $display("FAIL gap_timing got c0=%0d c2=%0d want 0 21", hs_c[0], hs_c[2]);
      end
   endtask

   task automatic test_overflow();
      int n = 0;
      logic done = 1'b0;
      for (int i = 0; i < 16; i++) push(8'(8'h40 + i));
      checks++;
      if ({fifo_count, overflow} !== {5'd16, 1'b0}) begin
         errors++; $display("FAIL ovf_full got cnt=%0d ovf=%b want 16 0", fifo_count, overflow);
      end
      for (int i = 0; i < 3; i++) push(8'hEE);
      checks++;
      if ({fifo_count, overflow} !== {5'd16, 1'b1}) begin
         errors++; $display("FAIL ovf_drop got cnt=%0d ovf=%b want 16 1", fifo_count, overflow);
      end
      tx_ready = 1'b1;
      start_frame(16'd16);
      for (int c = 0; c < 60; c++) begin
         wrfifo_pulse = (c == 0);
         wrfifo_data  = 8'h99;
         #1;
         if (c == 1) begin
            checks++;
            if (fifo_count !== 5'd16) begin errors++; $display("FAIL ovf_rw_full got cnt=%0d want 16", fifo_count); end
         end
         if (tx_valid && tx_ready) begin
            checks++;
            if (n >= 16) begin
               errors++; $display("FAIL ovf_extra got byte %h want none", tx_data);
            end else if ({tx_sop, tx_eop, tx_data} !== {(n == 0), (n == 15), 8'(8'h40 + n)}) begin
               errors++; $display("FAIL ovf_byte%0d got %b%b/%h want %b%b/%h", n, tx_sop, tx_eop, tx_data, (n == 0), (n == 15), 8'(8'h40 + n));
            end
            n++;
         end
         if (frame_done) begin done = 1'b1; break; end
         @(negedge clk);
      end
      wrfifo_pulse = 1'b0;
      @(negedge clk);
      checks++;
      if (!(done && n == 16)) begin errors++; $display("FAIL ovf_total got n=%0d done=%b want 16 1", n, done); end
      checks++;
      if ({overflow, fifo_count} !== {1'b0, 5'd1}) begin
         errors++; $display("FAIL ovf_clear got ovf=%b cnt=%0d want 0 1", overflow, fifo_count);
      end
   endtask

   task automatic test_leftover();
      tx_ready = 1'b1;
      start_frame(16'd1);
      checks++;
      if ({tx_valid, tx_sop, tx_eop, tx_data} !== {3'b111, 8'h99}) begin
         errors++; $display("FAIL left_byte got %b%b%b/%h want 111/99", tx_valid, tx_sop, tx_eop, tx_data);
      end
      @(negedge clk);
      checks++;
      if ({frame_done, fifo_count} !== {1'b1, 5'd0}) begin
         errors++; $display("FAIL left_done got done=%b cnt=%0d want 1 0", frame_done, fifo_count);
      end
      @(negedge clk);
   endtask

   task automatic test_bad_length();
      push(8'h88);
      start_frame(16'd0);
      checks++;
      if ({busy, frame_error, fifo_count} !== {2'b00, 5'd1}) begin
         errors++; $display("FAIL zero_len got busy=%b err=%b cnt=%0d want 0 0 1", busy, frame_error, fifo_count);
      end
      push(8'h89);
      push(8'h8A);
      start_frame(16'd17);
      checks++;
      if ({busy, frame_error, fifo_count} !== {2'b01, 5'd0}) begin
         errors++; $display("FAIL oversize got busy=%b err=%b cnt=%0d want 0 1 0", busy, frame_error, fifo_count);
      end
      @(negedge clk);
      checks++;
      if (frame_error !== 1'b0) begin errors++; $display("FAIL oversize_pulse got err=%b want 0", frame_error); end
   endtask

   task automatic test_timeout();
      int n = 0;
      int eops = 0;
      int err_c = -1;
      tx_ready = 1'b1;
      push(8'h5A);
      start_frame(16'd3);
      for (int c = 0; c < 200; c++) begin
         #1;
         if (tx_valid && tx_eop) eops++;
         if (tx_valid && tx_ready) begin
            checks++;
            if ({tx_sop, tx_data} !== {1'b1, 8'h5A} || n != 0) begin
               errors++; $display("FAIL tmo_byte%0d got s=%b d=%h want first 5A only", n, tx_sop, tx_data);
            end
            n++;
         end
         if (frame_error) begin
            err_c = c;
            checks++;
            if (busy !== 1'b0) begin errors++; $display("FAIL tmo_busy got %b want 0", busy); end
            break;
         end
         @(negedge clk);
      end
      checks++;
      if (err_c != 101) begin errors++; $display("FAIL tmo_cycle got %0d want 101", err_c); end
      checks++;
      if (n != 1 || eops != 0) begin errors++; $display("FAIL tmo_sent got n=%0d eops=%0d want 1 0", n, eops); end
      @(negedge clk);
      checks++;
      if (frame_error !== 1'b0) begin errors++; $display("FAIL tmo_pulse got err=%b want 0", frame_error); end
   endtask

   task automatic test_rst_mid();
      for (int i = 0; i < 6; i++) push(8'(8'h61 + i));
      tx_ready = 1'b1;
      start_frame(16'd6);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if ({tx_valid, tx_sop, tx_eop, busy, overflow, frame_done, frame_error, tx_data, fifo_count} !== '0) begin
         errors++; $display("FAIL rst_mid got v=%b s=%b e=%b busy=%b d=%h cnt=%0d want all 0", tx_valid, tx_sop, tx_eop, busy, tx_data, fifo_count);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({tx_valid, busy} !== 2'b00) begin errors++; $display("FAIL rst_quiet got v=%b busy=%b want 0 0", tx_valid, busy); end
      push(8'h77);
      start_frame(16'd1);
      checks++;
      if ({tx_valid, tx_sop, tx_eop, tx_data} !== {3'b111, 8'h77}) begin
         errors++; $display("FAIL rst_newframe got %b%b%b/%h want 111/77", tx_valid, tx_sop, tx_eop, tx_data);
      end
      @(negedge clk);
      checks++;
      if (frame_done !== 1'b1) begin errors++; $display("FAIL rst_newdone got %b want 1", frame_done); end
   endtask

   initial begin
      rst           = 1'b1;
      wrfifo_data   = 8'h00;
      wrfifo_pulse  = 1'b0;
      tx_en         = 1'b0;
      tx_datalength = 16'd0;
      tx_ready      = 1'b0;
      repeat (3) @(negedge clk);
      test_reset();
      rst = 1'b0;
      @(negedge clk);
      test_basic();
      test_ready_toggle();
      test_gap();
      test_overflow();
      test_leftover();
      test_bad_length();
      test_timeout();
      test_rst_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
